multicycle_control_unit: RTL and testbench

Main control FSM for the 16-bit multicycle CPU, directly upstream of the ALU control unit. Sequences each instruction through fetch, decode, execute, memory and write-back states, drives all datapath enables and mux selects, and produces the 2-bit ALUOp consumed by the ALU control unit. Memory accesses use a ready handshake, so memory latency is variable.

---
 rtl/cpu16_ctrl_pkg.sv | 83 ++++++++
 rtl/ctrl_opcode_class.sv | 24 ++
 rtl/multicycle_control_unit.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu16_ctrl_pkg.sv
// Shared types and constants for the 16-bit multicycle CPU control path:
// FSM state enum, opcode map, ALUOp / mux-select encodings, instruction
// classes and the bundled control-word struct.
package cpu16_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    WB_R     = 4'd8,
    WB_I     = 4'd9,
    WB_MEM   = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    TRAP     = 4'd13
  } state_e;

  // Opcode map (IR[15:12])
  localparam logic [3:0] OP_RA    = 4'b0000;
  localparam logic [3:0] OP_RB    = 4'b0001;
  localparam logic [3:0] OP_SHIFT = 4'b0010;
  localparam logic [3:0] OP_J     = 4'b0011;
  localparam logic [3:0] OP_LW    = 4'b0100;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_ADDI  = 4'b1001;
  localparam logic [3:0] OP_SUBI  = 4'b1010;
  localparam logic [3:0] OP_SLTI  = 4'b1011;

  // ALUOp handed to the ALU control unit
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Instruction classes used by the dispatch states
  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_LW      = 3'd2,
    CLS_SW      = 3'd3,
    CLS_BEQ     = 3'd4,
    CLS_J       = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_class_e;

  // One cycle's worth of datapath controls
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       memto_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       instr_done;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/ctrl_opcode_class.sv
// Combinational opcode decoder: maps IR[15:12] onto the instruction class
// that drives DECODE and MEM_ADDR dispatch. Unlisted opcodes are illegal.
module ctrl_opcode_class
  import cpu16_ctrl_pkg::*;
(
  input  logic [3:0]   opcode_i,
  output instr_class_e cls_o
);

  // Opcode to class lookup
  always_comb begin
    cls_o = CLS_ILLEGAL;
    case (opcode_i)
      OP_RA, OP_RB:                     cls_o = CLS_R;
      OP_SHIFT, OP_ADDI, OP_SUBI, OP_SLTI: cls_o = CLS_I;
      OP_LW:                            cls_o = CLS_LW;
      OP_SW:                            cls_o = CLS_SW;
      OP_BEQ:                           cls_o = CLS_BEQ;
      OP_J:                             cls_o = CLS_J;
      default:                          cls_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the 16-bit multicycle CPU. Sequences each instruction
// through fetch / decode / execute / memory / write-back and drives every
// datapath enable and mux select plus ALUOp for the ALU control unit.
//
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN. When defined an illegal
// opcode parks the FSM in TRAP with a sticky illegal_op; otherwise an
// illegal opcode retires as a NOP in DECODE and illegal_op is tied low.
//
// Memory handshake: MemRead/MemWrite and IorD are the request and are held
// constant while the FSM waits; mem_ready=1 means the memory completes the
// access in that same cycle, so the completing cycle's side effects
// (IRWrite/PCWrite in FETCH, instr_done in MEM_WR) are qualified by it.
// mem_ready is ignored in every other state.
//
// dbg_state_o exposes the current FSM state for observation only.
module multicycle_control_unit
  import cpu16_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       illegal_op,
  output state_e     dbg_state_o
);

  state_e       state_q;
  state_e       state_d;
  ctrl_t        ctrl;
  instr_class_e cls;

  // The branch decision (PCWriteCond & zero) is formed in the datapath.
  logic unused_zero;
  assign unused_zero = zero;

  ctrl_opcode_class u_opcode_class (
    .opcode_i (opcode),
    .cls_o    (cls)
  );

  // State register; reset drops straight to IDLE so every output is 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control-word decode
  always_comb begin
    state_d = state_q;
    ctrl    = CTRL_NONE;
    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        ctrl.iord      = 1'b0;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_TWO;
        ctrl.alu_op    = ALUOP_ADD;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = DECODE;
        end
      end

      DECODE: begin
        // Branch target PC + (imm<<1) is computed speculatively into ALUOut
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
        case (cls)
          CLS_R:          state_d = EXEC_R;
          CLS_I:          state_d = EXEC_I;
          CLS_LW, CLS_SW: state_d = MEM_ADDR;
          CLS_BEQ:        state_d = BRANCH;
          CLS_J:          state_d = JUMP;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_d = TRAP;
`else
            state_d         = FETCH;
            ctrl.instr_done = 1'b1;
`endif
          end
        endcase
      end

      EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_R;
        state_d        = WB_R;
      end

      EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_I;
        state_d        = WB_I;
      end

      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = (cls == CLS_LW) ? MEM_RD : MEM_WR;
      end

      MEM_RD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
        if (mem_ready) state_d = WB_MEM;
      end

      MEM_WR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
        if (mem_ready) begin
          ctrl.instr_done = 1'b1;
          state_d         = FETCH;
        end
      end

      WB_R: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.memto_reg  = 1'b0;
        ctrl.instr_done = 1'b1;
        state_d         = FETCH;
      end

      WB_I: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.reg_write  = 1'b1;
        ctrl.memto_reg  = 1'b0;
        ctrl.instr_done = 1'b1;
        state_d         = FETCH;
      end

      WB_MEM: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.memto_reg  = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = FETCH;
      end

      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
        state_d            = FETCH;
      end

      JUMP: begin
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = FETCH;
      end

      // Parked until reset; all controls stay low
      TRAP: state_d = TRAP;

      default: state_d = IDLE;
    endcase
  end

  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.memto_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign instr_done  = ctrl.instr_done;
  assign dbg_state_o = state_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
  // Sticky by construction: TRAP is only left through reset
  assign illegal_op = (state_q == TRAP);
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit: per-cycle expected control words
// and states are queued by the driver, a negedge monitor compares them and
// checks each instruction's cycle count against the timing table.
module tb_multicycle_control_unit;
  import cpu16_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic       ALUSrcA, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, instr_done, illegal_op;
  state_e     dbg_state;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .instr_done(instr_done), .illegal_op(illegal_op),
    .dbg_state_o(dbg_state)
  );

  // ---------------- expected-word format ----------------
  typedef struct packed {
    logic [1:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       memto_reg, reg_dst, reg_write, done, illegal;
  } ctl_t;

  typedef struct packed {
    state_e st;
    ctl_t   c;
  } exp_t;

  localparam int W = $bits(exp_t);

  logic [W-1:0] exp_q[$];
  int           len_q[$];
  int           checks = 0;
  int           failures = 0;
  bit           mon_en = 1'b0;
  logic [3:0]   cur_op = 4'b0;

  function automatic ctl_t get_act();
    ctl_t a;
    a = '{alu_op: ALUOp, src_a: ALUSrcA, src_b: ALUSrcB, pc_src: PCSource,
          pc_write: PCWrite, pc_write_cond: PCWriteCond, iord: IorD,
          mem_read: MemRead, mem_write: MemWrite, ir_write: IRWrite,
          memto_reg: MemtoReg, reg_dst: RegDst, reg_write: RegWrite,
          done: instr_done, illegal: illegal_op};
    return a;
  endfunction

  // ---------------- driver tasks ----------------
  // One clock cycle: drive inputs just after the edge and queue what the
  // DUT must show for the rest of that cycle.
  task automatic cyc(input state_e s, input ctl_t c, input logic rdy);
    exp_t e;
    @(posedge clk);
    #1;
    opcode    = cur_op;
    mem_ready = rdy;
    zero      = 1'($urandom_range(0, 1));
    e.st = s;
    e.c  = c;
    exp_q.push_back(e);
  endtask

  // Asynchronous reset asserted mid-cycle, held two cycles, released
  // just after an edge; the release cycle is IDLE, FETCH follows.
  task automatic do_reset();
    exp_t e;
    ctl_t z;
    z = '0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    len_q.delete();
    e.st = IDLE;
    e.c  = z;
    exp_q.push_back(e);
    #1;
    checks++;
    if (get_act() !== z || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_immediate state=%s ctl=%h required state=IDLE ctl=0",
               dbg_state.name(), get_act());
    end
    repeat (2) cyc(IDLE, z, 1'($urandom_range(0, 1)));
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    exp_q.push_back(e);
  endtask

  // Reference model for one instruction. fw / mw are the mem_ready=0 wait
  // cycles in the fetch and data-memory phases. abort_wr resets the CPU
  // during the first MEM_WR wait cycle of a store.
  task automatic run_instr(input logic [3:0] op, input int fw, input int mw,
                           input bit abort_wr);
    ctl_t c;
    int   kind;  // 0 R, 1 I, 2 LW, 3 SW, 4 BEQ, 5 J, 6 illegal
    int   len;
    case (op)
      4'b0000, 4'b0001:                   kind = 0;
      4'b0010, 4'b1001, 4'b1010, 4'b1011: kind = 1;
      4'b0100:                            kind = 2;
      4'b0101:                            kind = 3;
      4'b0110:                            kind = 4;
      4'b0011:                            kind = 5;
      default:                            kind = 6;
    endcase
    case (kind)
      0, 1:    len = 4;
      2:       len = 5 + mw;
      3:       len = 4 + mw;
      4, 5:    len = 3;
      default: len = 2;
    endcase
    len += fw;
`ifdef CTRL_ILLEGAL_TRAP_EN
    if (kind != 6 && !abort_wr) len_q.push_back(len);
`else
    if (!abort_wr) len_q.push_back(len);
`endif
    cur_op = op;

    // fetch: request held through the waits, IR/PC written on completion
    c = '0; c.mem_read = 1'b1; c.src_b = 2'b01;
    for (int i = 0; i < fw; i++) cyc(FETCH, c, 1'b0);
    c.ir_write = 1'b1; c.pc_write = 1'b1;
    cyc(FETCH, c, 1'b1);

    // decode
    c = '0; c.src_b = 2'b11;
    if (kind == 6) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      cyc(DECODE, c, 1'($urandom_range(0, 1)));
      c = '0; c.illegal = 1'b1;
      repeat (20) cyc(TRAP, c, 1'($urandom_range(0, 1)));
      do_reset();
`else
      c.done = 1'b1;
      cyc(DECODE, c, 1'($urandom_range(0, 1)));
`endif
      return;
    end
    cyc(DECODE, c, 1'($urandom_range(0, 1)));

    case (kind)
      0: begin
        c = '0; c.src_a = 1'b1; c.src_b = 2'b00; c.alu_op = 2'b10;
        cyc(EXEC_R, c, 1'($urandom_range(0, 1)));
        c = '0; c.reg_dst = 1'b1; c.reg_write = 1'b1; c.done = 1'b1;
        cyc(WB_R, c, 1'($urandom_range(0, 1)));
      end
      1: begin
        c = '0; c.src_a = 1'b1; c.src_b = 2'b10; c.alu_op = 2'b11;
        cyc(EXEC_I, c, 1'($urandom_range(0, 1)));
        c = '0; c.reg_write = 1'b1; c.done = 1'b1;
        cyc(WB_I, c, 1'($urandom_range(0, 1)));
      end
      2, 3: begin
        c = '0; c.src_a = 1'b1; c.src_b = 2'b10;
        cyc(MEM_ADDR, c, 1'($urandom_range(0, 1)));
        if (kind == 2) begin
          c = '0; c.iord = 1'b1; c.mem_read = 1'b1;
          for (int i = 0; i < mw; i++) cyc(MEM_RD, c, 1'b0);
          cyc(MEM_RD, c, 1'b1);
          c = '0; c.memto_reg = 1'b1; c.reg_write = 1'b1; c.done = 1'b1;
          cyc(WB_MEM, c, 1'($urandom_range(0, 1)));
        end else begin
          c = '0; c.iord = 1'b1; c.mem_write = 1'b1;
          if (abort_wr) begin
            cyc(MEM_WR, c, 1'b0);
            do_reset();
            return;
          end
          for (int i = 0; i < mw; i++) cyc(MEM_WR, c, 1'b0);
          c.done = 1'b1;
          cyc(MEM_WR, c, 1'b1);
        end
      end
      4: begin
        c = '0; c.src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
        c.pc_src = 2'b01; c.done = 1'b1;
        cyc(BRANCH, c, 1'($urandom_range(0, 1)));
      end
      default: begin
        c = '0; c.pc_src = 2'b10; c.pc_write = 1'b1; c.done = 1'b1;
        cyc(JUMP, c, 1'($urandom_range(0, 1)));
      end
    endcase
  endtask

  // ---------------- scoreboard monitor ----------------
  exp_t m_e;
  ctl_t m_act;
  int   m_cnt = 0;
  int   m_len;
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL exp_underflow t=%0t actual=empty_queue required=entry", $time);
      end else begin
        m_e   = exp_t'(exp_q.pop_front());
        m_act = get_act();
        checks++;
        if (m_act !== m_e.c || dbg_state !== m_e.st) begin
          failures++;
          $display("FAIL cycle_ctl t=%0t op=%b actual state=%s ctl=%h required state=%s ctl=%h",
                   $time, opcode, dbg_state.name(), m_act, m_e.st.name(), m_e.c);
        end
        if (m_e.st == IDLE) m_cnt = 0;
        else                m_cnt++;
        if (m_act.done) begin
          checks++;
          if (len_q.size() == 0) begin
            failures++;
            $display("FAIL instr_len t=%0t actual=unexpected_done required=no_done", $time);
          end else begin
            m_len = len_q.pop_front();
            if (m_len != m_cnt) begin
              failures++;
              $display("FAIL instr_len t=%0t actual=%0d required=%0d", $time, m_cnt, m_len);
            end
          end
          m_cnt = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] op;
    rst_n     = 1'b0;
    opcode    = 4'b0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    do_reset();

    run_instr(4'b0001, 0, 0, 1'b0);  // ADD, zero-wait: 4 cycles
    run_instr(4'b0100, 0, 2, 1'b0);  // LW, 2 waits in MEM_RD: 7 cycles
    run_instr(4'b0110, 0, 0, 1'b0);  // BEQ
    run_instr(4'b1011, 0, 0, 1'b0);  // SLTI
    run_instr(4'b0101, 0, 0, 1'b0);  // SW zero-wait
    run_instr(4'b0011, 1, 0, 1'b0);  // J with a fetch wait
`ifndef CTRL_ILLEGAL_TRAP_EN
    run_instr(4'b1111, 0, 0, 1'b0);  // illegal retires as NOP
`endif
    run_instr(4'b0101, 0, 3, 1'b1);  // SW aborted by reset in MEM_WR
    run_instr(4'b0000, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (op inside {4'b0111, 4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111}) op = 4'b0001;
`endif
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    run_instr(4'b1111, 0, 0, 1'b0);  // TRAP for 20 cycles, then reset
    run_instr(4'b0010, 0, 0, 1'b0);
`endif

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL exp_drain actual=%0d required=0", exp_q.size());
    end
    checks++;
    if (len_q.size() != 0) begin
      failures++;
      $display("FAIL missing_done actual=%0d_pending required=0", len_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
